// File: rtl/isa_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : isa_io_port_bank
// Description : Clocked ISA I/O port bank. Decodes an aligned block of
//               NUM_PORTS I/O addresses at BASE_ADDR, latches host writes
//               into output ports (pa) and returns sampled input ports (pb)
//               on host reads. The asynchronous ior_n/iow_n strobes are
//               brought into the clk domain through 2-flop synchronisers.
//               Optional write-interrupt flag: define ISA_IO_PORT_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module isa_io_port_bank #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_PORTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h2B0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           sa,
  input  logic [DATA_W-1:0]           sd_in,
  output logic [DATA_W-1:0]           sd_out,
  output logic                        sd_oe,
  input  logic                        ior_n,
  input  logic                        iow_n,
  input  logic                        aen,
  output logic [NUM_PORTS*DATA_W-1:0] pa_out,
  input  logic [NUM_PORTS*DATA_W-1:0] pb_in,
  output logic [NUM_PORTS-1:0]        wr_pulse,
  output logic                        irq
);

  localparam int unsigned      IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Strobe synchronisers. Bit 0 is the metastability flop, bit 1 is the
  // synchronised strobe and bit 2 its previous value for edge detection.
  // settle_q holds off edge detection until the shift chains carry real pin
  // values after reset, so a strobe held low through reset is not mistaken
  // for a fresh falling edge.
  // --------------------------------------------------------------------------
  logic [2:0] ior_sh_q, ior_sh_d;
  logic [2:0] iow_sh_q, iow_sh_d;
  logic [1:0] settle_q, settle_d;

  // Next-state for the synchroniser chains and the post-reset settle counter
  always_comb begin
    ior_sh_d = {ior_sh_q[1:0], ior_n};
    iow_sh_d = {iow_sh_q[1:0], iow_n};
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  // Synchroniser and settle registers; chains idle high (strobes inactive)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ior_sh_q <= 3'b111;
      iow_sh_q <= 3'b111;
      settle_q <= 2'd0;
    end else begin
      ior_sh_q <= ior_sh_d;
      iow_sh_q <= iow_sh_d;
      settle_q <= settle_d;
    end
  end

  logic             edge_en;
  logic             ior_sync;
  logic             iow_sync;
  logic             ior_fall;
  logic             ior_rise;
  logic             iow_fall;
  logic             iow_rise;
  logic             hit;
  logic             bus_err;
  logic [IDX_W-1:0] sa_idx;

  assign edge_en  = (settle_q == 2'd3);
  assign ior_sync = ior_sh_q[1];
  assign iow_sync = iow_sh_q[1];
  assign ior_fall = edge_en &  ior_sh_q[2] & ~ior_sh_q[1];
  assign ior_rise = edge_en & ~ior_sh_q[2] &  ior_sh_q[1];
  assign iow_fall = edge_en &  iow_sh_q[2] & ~iow_sh_q[1];
  assign iow_rise = edge_en & ~iow_sh_q[2] &  iow_sh_q[1];

  // Address decode is only meaningful when the DMA controller does not own
  // the bus; both strobes active at once is a host bus error.
  assign hit     = ~aen && (sa[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]);
  assign sa_idx  = sa[IDX_W-1:0];
  assign bus_err = ~ior_sync & ~iow_sync;

  // --------------------------------------------------------------------------
  // Transaction FSM and port registers
  // --------------------------------------------------------------------------
  logic [NUM_PORTS-1:0][DATA_W-1:0] pb_word;
  logic [NUM_PORTS-1:0][DATA_W-1:0] pa_q, pa_d;
  logic [NUM_PORTS-1:0]             wr_pulse_q, wr_pulse_d;
  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [DATA_W-1:0]                sd_out_q, sd_out_d;
  logic                             oe_q, oe_d;

  assign pb_word = pb_in;

  // Next-state logic: enter RD/WR on a decoded strobe fall, leave on that
  // same strobe's rise; write data is captured at the trailing edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sd_out_d   = sd_out_q;
    oe_d       = oe_q;
    pa_d       = pa_q;
    wr_pulse_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit && !bus_err) begin
          if (ior_fall) begin
            state_d  = ST_RD;
            idx_d    = sa_idx;
            sd_out_d = pb_word[sa_idx];
            oe_d     = 1'b1;
          end else if (iow_fall) begin
            state_d = ST_WR;
            idx_d   = sa_idx;
          end
        end
      end
      ST_RD: begin
        if (ior_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      end
      ST_WR: begin
        if (iow_rise) begin
          state_d           = ST_IDLE;
          pa_d[idx_q]       = sd_in;
          wr_pulse_d[idx_q] = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset discards any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sd_out_q   <= '0;
      oe_q       <= 1'b0;
      pa_q       <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sd_out_q   <= sd_out_d;
      oe_q       <= oe_d;
      pa_q       <= pa_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // The bus is released in the very cycle the read strobe rise is seen, and
  // immediately while reset is asserted, rather than one clock later.
  assign sd_oe    = oe_q & ~ior_rise & rst_n;
  assign sd_out   = sd_out_q;
  assign pa_out   = pa_q;
  assign wr_pulse = wr_pulse_q;

`ifdef ISA_IO_PORT_IRQ_EN
  // --------------------------------------------------------------------------
  // Sticky write interrupt: set after any write pulse, cleared when a read of
  // the last port completes. A simultaneous set overrides the clear.
  // --------------------------------------------------------------------------
  logic irq_q, irq_d;

  // Clear on last-port read completion first, so a set in the same cycle wins
  always_comb begin
    irq_d = irq_q;
    if ((state_q == ST_RD) && ior_rise && (idx_q == LAST_IDX)) begin
      irq_d = 1'b0;
    end
    if (|wr_pulse_q) begin
      irq_d = 1'b1;
    end
  end

  // Interrupt flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_last_idx;
  assign unused_last_idx = &LAST_IDX;
  assign irq             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isa_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_isa_io_port_bank
// Description : Self-checking bench for isa_io_port_bank. A transaction-level
//               model predicts every output each cycle from the strobe
//               timing the bench itself drives; directed cases pin the model
//               with literal values, then randomized traffic follows.
//               Define ISA_IO_PORT_IRQ_EN to check the interrupt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isa_io_port_bank;

  localparam int         NP   = 4;
  localparam logic [9:0] BASE = 10'h2B0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sa;
  logic [7:0]  sd_in;
  logic [7:0]  sd_out;
  logic        sd_oe;
  logic        ior_n;
  logic        iow_n;
  logic        aen;
  logic [31:0] pa_out;
  logic [31:0] pb_in;
  logic [3:0]  wr_pulse;
  logic        irq;

  always #5 clk = ~clk;

  isa_io_port_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sa       (sa),
    .sd_in    (sd_in),
    .sd_out   (sd_out),
    .sd_oe    (sd_oe),
    .ior_n    (ior_n),
    .iow_n    (iow_n),
    .aen      (aen),
    .pa_out   (pa_out),
    .pb_in    (pb_in),
    .wr_pulse (wr_pulse),
    .irq      (irq)
  );

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  // Model state: what each output must be in the current cycle
  logic       exp_oe;
  logic [7:0] exp_sd;
  logic [7:0] exp_pa [NP];
  logic [3:0] exp_wr;
  logic       exp_irq;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [31:0] exp_pa_word();
    return {exp_pa[3], exp_pa[2], exp_pa[1], exp_pa[0]};
  endfunction

  function automatic bit is_hit(input logic [9:0] a, input logic a_en);
    return (a_en == 1'b0) && ((a >> 2) == (BASE >> 2));
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("sd_oe", 32'(sd_oe), 32'(exp_oe));
      check("pa_out", pa_out, exp_pa_word());
      check("wr_pulse", 32'(wr_pulse), 32'(exp_wr));
      check("irq", 32'(irq), 32'(exp_irq));
      if (exp_oe) check("sd_out", 32'(sd_out), 32'(exp_sd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read: strobe low for len cycles. Output enable appears 3 clocks after the
  // pin fall and drops 2 clocks after the pin rise (synchroniser delay).
  task automatic do_read(input logic [9:0] addr, input logic a_en, input int len,
                         output logic [7:0] got, output int oe_cnt);
    bit hit;
    int idx;
    hit    = is_hit(addr, a_en);
    idx    = int'(addr[1:0]);
    got    = 8'h00;
    oe_cnt = 0;
    sa     = addr;
    aen    = a_en;
    ior_n  = 1'b0;
    for (int t = 1; t <= len; t++) begin
      tick();
      if (t == 3) begin
        if (hit) begin
          exp_oe = 1'b1;
          exp_sd = pb_in[idx*8 +: 8];
        end
        sa    = 10'($urandom);
        aen   = 1'($urandom);
        pb_in = $urandom;
      end
      if (len >= 6 && t == 4) iow_n = 1'b0;
      if (len >= 6 && t == 5) iow_n = 1'b1;
      @(negedge clk);
      if (sd_oe) begin
        oe_cnt++;
        got = sd_out;
      end
    end
    ior_n = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      tick();
      if (r == 2) exp_oe = 1'b0;
`ifdef ISA_IO_PORT_IRQ_EN
      if (r == 3 && hit && idx == NP - 1) exp_irq = 1'b0;
`endif
      @(negedge clk);
      if (sd_oe) begin
        oe_cnt++;
        got = sd_out;
      end
    end
  endtask

  // Write: data is only valid in the cycle the synchronised rise is seen;
  // the port updates and pulses 3 clocks after the pin rise.
  task automatic do_write(input logic [9:0] addr, input logic a_en, input logic [7:0] data,
                          input int len, output logic [3:0] pulse);
    bit hit;
    int idx;
    hit   = is_hit(addr, a_en);
    idx   = int'(addr[1:0]);
    pulse = 4'h0;
    sa    = addr;
    aen   = a_en;
    sd_in = 8'($urandom);
    iow_n = 1'b0;
    for (int t = 1; t <= len; t++) begin
      tick();
      if (t == 3) begin
        sa  = 10'($urandom);
        aen = 1'($urandom);
      end
      sd_in = 8'($urandom);
      if (len >= 6 && t == 4) ior_n = 1'b0;
      if (len >= 6 && t == 5) ior_n = 1'b1;
      @(negedge clk);
    end
    iow_n = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      tick();
      if (r == 2) sd_in = data;
      if (r == 3) begin
        sd_in = 8'($urandom);
        if (hit) begin
          exp_pa[idx]  = data;
          exp_wr[idx]  = 1'b1;
        end
      end
      if (r == 4) begin
        exp_wr = 4'h0;
`ifdef ISA_IO_PORT_IRQ_EN
        if (hit) exp_irq = 1'b1;
`endif
      end
      @(negedge clk);
      if (r == 3) pulse = wr_pulse;
    end
  endtask

  // Both strobes fall together: a bus error, nothing may happen
  task automatic do_buserr(input logic [9:0] addr, input int len, output int oe_cnt);
    oe_cnt = 0;
    sa     = addr;
    aen    = 1'b0;
    sd_in  = 8'($urandom);
    ior_n  = 1'b0;
    iow_n  = 1'b0;
    for (int t = 1; t <= len + 4; t++) begin
      tick();
      if (t == len) begin
        ior_n = 1'b1;
        iow_n = 1'b1;
      end
      @(negedge clk);
      if (sd_oe) oe_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pb_in = $urandom;
      sa    = 10'($urandom);
      sd_in = 8'($urandom);
      aen   = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) exp_pa[k] = 8'h00;
    exp_oe  = 1'b0;
    exp_sd  = 8'h00;
    exp_wr  = 4'h0;
    exp_irq = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] got;
    logic [3:0] pls;
    int         cnt;
    int         kind;
    logic [9:0] addr;
    logic       a_en;
    int         len;

    model_reset();
    rst_n = 1'b0;
    ior_n = 1'b0;
    iow_n = 1'b1;
    aen   = 1'b0;
    sa    = 10'h2B1;
    sd_in = 8'h00;
    pb_in = 32'h0000_3C00;

    // Reset with the read strobe already low
    tick();
    chk_en = 1'b1;
    check("rst_pa_out", pa_out, 32'h0);
    check("rst_sd_oe", 32'(sd_oe), 32'h0);
    check("rst_sd_out", 32'(sd_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sd_oe) cnt++;
      tick();
    end
    check("held_strobe_no_read", 32'(cnt), 32'd0);
    ior_n = 1'b1;
    idle(4);

    // Write 0xA5 to port 2
    do_write(10'h2B2, 1'b0, 8'hA5, 6, pls);
    check("wr_port2_pulse", 32'(pls), 32'h4);
    check("wr_port2_pa", pa_out, 32'h00A5_0000);
    idle(2);

    // Read port 1 = 0x3C, strobe low 8 clocks -> 7 enabled cycles
    pb_in = 32'h0000_3C00;
    do_read(10'h2B1, 1'b0, 8, got, cnt);
    check("rd_port1_data", 32'(got), 32'h3C);
    check("rd_port1_oe_cycles", 32'(cnt), 32'd7);
    idle(2);

    // Misses: out-of-block addresses and DMA cycle
    do_write(10'h2B4, 1'b0, 8'hFF, 6, pls);
    check("miss_2b4_pulse", 32'(pls), 32'h0);
    do_write(10'h3B0, 1'b0, 8'hFF, 5, pls);
    check("miss_3b0_pulse", 32'(pls), 32'h0);
    do_write(10'h2B0, 1'b1, 8'hFF, 6, pls);
    check("miss_aen_pulse", 32'(pls), 32'h0);
    do_read(10'h2B0, 1'b1, 6, got, cnt);
    check("miss_aen_read_oe", 32'(cnt), 32'd0);
    check("miss_pa_unchanged", pa_out, 32'h00A5_0000);

    // Simultaneous strobes
    do_buserr(10'h2B0, 6, cnt);
    check("buserr_oe", 32'(cnt), 32'd0);
    check("buserr_pa", pa_out, 32'h00A5_0000);
    idle(1);

    // Interrupt flag sequence
    do_write(10'h2B0, 1'b0, 8'h11, 6, pls);
    check("irq_wr_pa", pa_out, 32'h00A5_0011);
`ifdef ISA_IO_PORT_IRQ_EN
    check("irq_after_write", 32'(irq), 32'h1);
`else
    check("irq_after_write", 32'(irq), 32'h0);
`endif
    do_read(10'h2B1, 1'b0, 5, got, cnt);
`ifdef ISA_IO_PORT_IRQ_EN
    check("irq_after_rd1", 32'(irq), 32'h1);
`else
    check("irq_after_rd1", 32'(irq), 32'h0);
`endif
    do_read(10'h2B3, 1'b0, 5, got, cnt);
    check("irq_after_rd3", 32'(irq), 32'h0);
    idle(2);

    // Reset in the middle of a write with the write strobe held low
    sa    = 10'h2B1;
    aen   = 1'b0;
    sd_in = 8'h77;
    iow_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick();
    end
    iow_n = 1'b1;
    idle(5);
    check("midrst_pa", pa_out, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) addr = 10'($urandom);
      else addr = BASE | 10'($urandom_range(0, 3));
      a_en = ($urandom_range(0, 4) == 0);
      len  = $urandom_range(3, 8);
      if (kind < 4) do_read(addr, a_en, len, got, cnt);
      else if (kind < 8) do_write(addr, a_en, 8'($urandom), len, pls);
      else do_buserr(addr, len, cnt);
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
